// File: rtl/spi_cfg_pkg.sv
// Shared command codes and FSM encoding for the SPI configuration sequencer.
package spi_cfg_pkg;

  localparam logic [7:0] CMD_WRITE   = 8'hA5;
  localparam logic [7:0] CMD_CLR_ERR = 8'hC3;
  localparam logic [7:0] CMD_REG_RST = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_DISCARD = 3'd4
  } state_e;

endpackage

// File: rtl/spi_cfg_ctrl_if.sv
// Byte stream from the SPI receiver plus the raw chip select.
// The receiver presents rx_data_i together with a one-cycle active-low byte_strobe_n_i;
// there is no back-pressure, every strobe is a byte that must be consumed that cycle.
interface spi_cfg_ctrl_if;
  logic [7:0] rx_data_i;
  logic       byte_strobe_n_i;
  logic       spi_csn_i;

  modport master (output rx_data_i, output byte_strobe_n_i, output spi_csn_i);
  modport slave  (input  rx_data_i, input  byte_strobe_n_i, input  spi_csn_i);
endinterface

// File: rtl/cfg_regbank.sv
// NUM_REGS x 8 configuration register bank with single write port and clear-all.
// SPI_CFG_SHADOW_EN adds a shadow bank that is committed or reloaded once per frame.
module cfg_regbank #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [7:0]            wr_data_i,
  input  logic                  clr_i,
`ifdef SPI_CFG_SHADOW_EN
  input  logic                  commit_i,
  input  logic                  abort_i,
`endif
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic                  update_o
);

  logic [7:0] active_q [NUM_REGS];
  logic [7:0] active_d [NUM_REGS];
  logic       update_q, update_d;

`ifdef SPI_CFG_SHADOW_EN
  logic [7:0] shadow_q [NUM_REGS];
  logic [7:0] shadow_d [NUM_REGS];

  // Commit sees this cycle's write too, so a byte coinciding with frame end is included.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    update_d = 1'b0;
    if (clr_i) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_d[i] = 8'h00;
    end else if (wr_en_i) begin
      shadow_d[wr_addr_i] = wr_data_i;
    end
    if (commit_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_d[i] = shadow_d[i];
        if (shadow_d[i] != active_q[i]) update_d = 1'b1;
      end
    end else if (abort_i) begin
      shadow_d = active_q;
    end
  end
`else
  always_comb begin
    active_d = active_q;
    update_d = 1'b0;
    if (clr_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (active_q[i] != 8'h00) update_d = 1'b1;
        active_d[i] = 8'h00;
      end
    end else if (wr_en_i) begin
      active_d[wr_addr_i] = wr_data_i;
      update_d = (active_q[wr_addr_i] != wr_data_i);
    end
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        active_q[i] <= 8'h00;
`ifdef SPI_CFG_SHADOW_EN
        shadow_q[i] <= 8'h00;
`endif
      end
      update_q <= 1'b0;
    end else begin
      active_q <= active_d;
`ifdef SPI_CFG_SHADOW_EN
      shadow_q <= shadow_d;
`endif
      update_q <= update_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_o[8*i +: 8] = active_q[i];
  end

  assign update_o = update_q;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// Frame parser behind the SPI byte receiver: command, start address, data bytes into cfg_regbank.
// Optional SPI_CFG_SHADOW_EN makes each frame's register writes atomic.
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  spi_cfg_ctrl_if.slave         spi_if,
  output logic [NUM_REGS*8-1:0] cfg_regs_o,
  output logic                  cfg_update_o,
  output logic                  err_o,
  output logic [7:0]            frame_cnt_o,
  output state_e                state_dbg_o
);

  localparam logic [8:0] NUM_REGS_W = 9'(NUM_REGS);

  logic        csn_meta_q, csn_meta_d;
  logic        csn_sync_q, csn_sync_d;
  logic        csn_prev_q, csn_prev_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        armed_q, armed_d;
  state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic        err_q, err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        frame_err_q, frame_err_d;

  logic        frame_end;
  logic        byte_vld;
  logic        err_raise;
  logic        wr_en;
  logic        clr_all;
  logic        commit;
  logic        abort;

  assign frame_end = csn_sync_q & ~csn_prev_q;
  assign byte_vld  = ~spi_if.byte_strobe_n_i & (state_q != ST_IDLE);

  // Synchroniser stages are preset high; sync_vld marks when csn_sync_q reflects the real pin,
  // so a frame already in progress at reset release is skipped until csn is seen high.
  always_comb begin
    csn_meta_d = spi_if.spi_csn_i;
    csn_sync_d = csn_meta_q;
    csn_prev_d = csn_sync_q;
    sync_vld_d = {sync_vld_q[0], 1'b1};
    armed_d    = armed_q | (sync_vld_q[1] & csn_sync_q);
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    err_d       = err_q;
    frame_cnt_d = frame_cnt_q;
    frame_err_d = frame_err_q;
    err_raise   = 1'b0;
    wr_en       = 1'b0;
    clr_all     = 1'b0;
    commit      = 1'b0;
    abort       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        frame_err_d = 1'b0;
        if (armed_q && !csn_sync_q) state_d = ST_CMD;
      end
      ST_CMD: if (byte_vld) begin
        case (spi_if.rx_data_i)
          CMD_WRITE:   state_d = ST_ADDR;
          CMD_CLR_ERR: begin err_d = 1'b0; state_d = ST_DISCARD; end
          CMD_REG_RST: begin clr_all = 1'b1; state_d = ST_DISCARD; end
          default:     begin err_raise = 1'b1; state_d = ST_DISCARD; end
        endcase
      end
      ST_ADDR: if (byte_vld) begin
        if ({1'b0, spi_if.rx_data_i} < NUM_REGS_W) begin
          ptr_d   = spi_if.rx_data_i[ADDR_W-1:0];
          state_d = ST_DATA;
        end else begin
          err_raise = 1'b1;
          state_d   = ST_DISCARD;
        end
      end
      ST_DATA: if (byte_vld) begin
        wr_en = 1'b1;
        ptr_d = ptr_q + ADDR_W'(1);
      end
      ST_DISCARD: ;
      default: state_d = ST_IDLE;
    endcase

    if (err_raise) begin
      err_d       = 1'b1;
      frame_err_d = 1'b1;
    end

    // A byte arriving with frame end has already been handled above; now close the frame.
    if (frame_end && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      frame_cnt_d = frame_cnt_q + 8'd1;
      commit      = ~frame_err_d;
      abort       = frame_err_d;
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csn_meta_q  <= 1'b1;
      csn_sync_q  <= 1'b1;
      csn_prev_q  <= 1'b1;
      sync_vld_q  <= 2'b00;
      armed_q     <= 1'b0;
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      err_q       <= 1'b0;
      frame_cnt_q <= 8'd0;
      frame_err_q <= 1'b0;
    end else begin
      csn_meta_q  <= csn_meta_d;
      csn_sync_q  <= csn_sync_d;
      csn_prev_q  <= csn_prev_d;
      sync_vld_q  <= sync_vld_d;
      armed_q     <= armed_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  cfg_regbank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regbank (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (ptr_q),
    .wr_data_i (spi_if.rx_data_i),
    .clr_i     (clr_all),
`ifdef SPI_CFG_SHADOW_EN
    .commit_i  (commit),
    .abort_i   (abort),
`endif
    .regs_o    (cfg_regs_o),
    .update_o  (cfg_update_o)
  );

`ifndef SPI_CFG_SHADOW_EN
  logic unused_frame_sig;
  assign unused_frame_sig = commit | abort | frame_err_q;
`endif

  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
  assign state_dbg_o = state_q;

endmodule
